dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the pipeline memory stage (CPU) and an external requester (program/data loader, debug).
- Sits between the memory-cycle stage and the data RAM.
- Drives a stall to the pipeline while a CPU access cannot complete.
- One access in flight at a time; fixed, parameterised RAM read latency.

---
 rtl/dmem_arb_pkg.sv | 10 +
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arb_rd_tracker.sv | 35 +++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic {IDLE, RD_WAIT} state_t;
   typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

   localparam int MEM_LAT_MAX = 4;
   localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the arbiter: CPU memory stage, external requester and data RAM.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;
   logic              cpu_stall;

   logic              ext_req;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_gnt;
   logic [DATA_W-1:0] ext_rdata;
   logic              ext_rvalid;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_rvalid, cpu_stall,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_gnt, ext_rdata, ext_rvalid,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Requesters and RAM side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_rvalid, cpu_stall,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_gnt, ext_rdata, ext_rvalid,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arb_rd_tracker.sv
// Read-latency tracker: counts MEM_LAT cycles after a read issue and
// emits a one-cycle return pulse tagged with the issuing owner.
module dmem_arb_rd_tracker
   import dmem_arb_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   input  owner_t start_owner,
   output logic   ret,
   output owner_t ret_owner
);

   logic [LAT_CNT_W-1:0] cnt;
   owner_t               owner_q;

   // Counter loads MEM_LAT at issue, so a value of 1 marks the return cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         owner_q <= OWN_EXT;
      end else if (start) begin
         cnt     <= LAT_CNT_W'(MEM_LAT);
         owner_q <= start_owner;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign ret       = (cnt == LAT_CNT_W'(1));
   assign ret_owner = owner_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU memory stage and an external
// requester. Optional performance counters are enabled with DMEM_ARB_PERF_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0]   perf_stall_cnt,
   output logic [31:0]   perf_ext_cnt
`endif
);

   if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
      $error("dmem_arbiter: MEM_LAT out of range 1..%0d", MEM_LAT_MAX);
   end

   state_t            state, state_nxt;
   owner_t            last_owner;
   logic              issue_cpu, issue_ext, issue_rd;
   logic              ret;
   owner_t            ret_owner;
   logic              cpu_ret, ext_ret;
   logic [ADDR_W-1:0] issue_addr;
   logic [DATA_W-1:0] issue_wdata;
   logic              issue_we;
   logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;

   dmem_arb_rd_tracker #(.MEM_LAT(MEM_LAT)) u_rd_tracker (
      .clk        (clk),
      .rst        (rst),
      .start      (issue_rd),
      .start_owner(issue_cpu ? OWN_CPU : OWN_EXT),
      .ret        (ret),
      .ret_owner  (ret_owner)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_owner <= OWN_EXT;
      end else begin
         state <= state_nxt;
         if (issue_cpu)      last_owner <= OWN_CPU;
         else if (issue_ext) last_owner <= OWN_EXT;
      end
   end

   // Pick: a lone requester wins; on conflict the one that did not win last time.
   always_comb begin
      issue_cpu = 1'b0;
      issue_ext = 1'b0;
      state_nxt = state;
      if (state == IDLE) begin
         if (bus.cpu_req && (!bus.ext_req || last_owner == OWN_EXT)) issue_cpu = 1'b1;
         else if (bus.ext_req)                                        issue_ext = 1'b1;
      end
      issue_rd = (issue_cpu && !bus.cpu_we) || (issue_ext && !bus.ext_we);
      case (state)
         IDLE:    if (issue_rd) state_nxt = RD_WAIT;
         RD_WAIT: if (ret)      state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_comb begin
      issue_we    = 1'b0;
      issue_addr  = '0;
      issue_wdata = '0;
      if (issue_cpu) begin
         issue_we    = bus.cpu_we;
         issue_addr  = bus.cpu_addr;
         issue_wdata = bus.cpu_wdata;
      end else if (issue_ext) begin
         issue_we    = bus.ext_we;
         issue_addr  = bus.ext_addr;
         issue_wdata = bus.ext_wdata;
      end
   end

   assign bus.mem_en    = issue_cpu || issue_ext;
   assign bus.mem_we    = issue_we;
   assign bus.mem_addr  = issue_addr;
   assign bus.mem_wdata = issue_wdata;
   assign bus.ext_gnt   = issue_ext;

   assign cpu_ret = ret && (ret_owner == OWN_CPU);
   assign ext_ret = ret && (ret_owner == OWN_EXT);

   // Returned data passes straight through; the held copy covers later cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
      end else begin
         if (cpu_ret) cpu_rdata_q <= bus.mem_rdata;
         if (ext_ret) ext_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.cpu_rvalid = cpu_ret;
   assign bus.ext_rvalid = ext_ret;
   assign bus.cpu_rdata  = cpu_ret ? bus.mem_rdata : cpu_rdata_q;
   assign bus.ext_rdata  = ext_ret ? bus.mem_rdata : ext_rdata_q;
   assign bus.cpu_stall  = bus.cpu_req && !(issue_cpu && bus.cpu_we) && !cpu_ret;

`ifdef DMEM_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt <= '0;
         perf_ext_cnt   <= '0;
      end else begin
         if (bus.cpu_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (issue_ext)     perf_ext_cnt   <= perf_ext_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with MEM_LAT=2 and a behavioural RAM.
module tb_dmem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic clk;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [31:0] cpu_q[$];
   logic [31:0] ext_q[$];
   logic [31:0] exp_d;
   logic [5:0]  fl;
   int          n;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_stall_cnt, perf_ext_cnt;
`endif

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef DMEM_ARB_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt)
      , .perf_ext_cnt(perf_ext_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: two-cycle read pipeline, junk on the data bus when idle.
   logic [31:0] ram [0:255];
   logic [31:0] rd_p0, rd_p1;
   always @(posedge clk) begin
      if (!rst) begin
         ram[8'h40] <= 32'hDEAD_BEEF;
         ram[8'h44] <= 32'h1234_5678;
      end else if (bus.mem_en && bus.mem_we) begin
         ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end
      rd_p0 <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr[7:0]] : $urandom;
      rd_p1 <= rd_p0;
   end
   assign bus.mem_rdata = rd_p1;

   function automatic logic [5:0] flags();
      return {bus.mem_en, bus.mem_we, bus.cpu_stall, bus.cpu_rvalid, bus.ext_gnt, bus.ext_rvalid};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      smp();
      n_chk++;
      if ({flags(), bus.cpu_rdata, bus.ext_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: flags=%b cpu_rdata=%h ext_rdata=%h required all 0",
                  flags(), bus.cpu_rdata, bus.ext_rdata);
      end
`ifdef DMEM_ARB_PERF_EN
      n_chk++;
      if ({perf_stall_cnt, perf_ext_cnt} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_perf: stall=%0d ext=%0d required 0", perf_stall_cnt, perf_ext_cnt);
      end
`endif
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_cpu_load();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
      cpu_q.push_back(32'hDEAD_BEEF);
      smp();
      n_chk++;
      if ({flags(), bus.mem_addr} !== {6'b101000, 32'h40}) begin
         n_fail++; $display("FAIL load_issue: flags=%b addr=%h required 101000 00000040", flags(), bus.mem_addr);
      end
      tick(); smp();
      n_chk++;
      if (flags() !== 6'b001000) begin
         n_fail++; $display("FAIL load_wait: flags=%b required 001000", flags());
      end
      tick(); smp();
      exp_d = cpu_q.pop_front();
      n_chk++;
      if ({flags(), bus.cpu_rdata} !== {6'b000100, exp_d}) begin
         n_fail++; $display("FAIL load_return: flags=%b rdata=%h required 000100 %h", flags(), bus.cpu_rdata, exp_d);
      end
`ifdef DMEM_ARB_PERF_EN
      n_chk++;
      if (perf_stall_cnt !== 32'd2) begin
         n_fail++; $display("FAIL perf_stall: got %0d required 2", perf_stall_cnt);
      end
`endif
      tick();
      bus.cpu_addr = 32'h44;
      cpu_q.push_back(32'h1234_5678);
      smp();
      n_chk++;
      if ({flags(), bus.mem_addr, bus.cpu_rdata} !== {6'b101000, 32'h44, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL load_reissue_hold: flags=%b addr=%h rdata=%h required 101000 00000044 deadbeef",
                            flags(), bus.mem_addr, bus.cpu_rdata);
      end
      tick(); tick(); smp();
      exp_d = cpu_q.pop_front();
      n_chk++;
      if ({flags(), bus.cpu_rdata} !== {6'b000100, exp_d}) begin
         n_fail++; $display("FAIL load2_return: flags=%b rdata=%h required 000100 %h", flags(), bus.cpu_rdata, exp_d);
      end
      tick();
      bus.cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
         bus.cpu_addr = 32'h10 + 32'(4 * i); bus.cpu_wdata = 32'(5 + i);
         smp();
         n_chk++;
         if ({flags(), bus.mem_addr, bus.mem_wdata} !== {6'b110000, 32'h10 + 32'(4 * i), 32'(5 + i)}) begin
            n_fail++; $display("FAIL store_%0d: flags=%b addr=%h wdata=%h required 110000 %h %h", i, flags(),
                               bus.mem_addr, bus.mem_wdata, 32'h10 + 32'(4 * i), 32'(5 + i));
         end
         tick();
      end
      bus.cpu_we = 1'b0; bus.cpu_addr = 32'h14;
      cpu_q.push_back(32'd6);
      n = 0;
      smp();
      while (!bus.cpu_rvalid && n < 8) begin
         tick(); smp(); n++;
      end
      exp_d = cpu_q.pop_front();
      n_chk++;
      if (n !== LAT || bus.cpu_rdata !== exp_d) begin
         n_fail++; $display("FAIL store_readback: cycles=%0d rdata=%h required %0d %h", n, bus.cpu_rdata, LAT, exp_d);
      end
      tick();
      bus.cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_conflict();
      apply_reset();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
      bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h80; bus.ext_wdata = 32'hA5A5_A5A5;
      cpu_q.push_back(32'hDEAD_BEEF);
      smp();
      n_chk++;
      if ({flags(), bus.mem_addr} !== {6'b101000, 32'h40}) begin
         n_fail++; $display("FAIL conflict1_cpu_first: flags=%b addr=%h required 101000 00000040", flags(), bus.mem_addr);
      end
      tick(); smp();
      n_chk++;
      if (flags() !== 6'b001000) begin
         n_fail++; $display("FAIL conflict1_wait: flags=%b required 001000", flags());
      end
      tick(); smp();
      exp_d = cpu_q.pop_front();
      n_chk++;
      if ({flags(), bus.cpu_rdata} !== {6'b000100, exp_d}) begin
         n_fail++; $display("FAIL conflict1_return: flags=%b rdata=%h required 000100 %h", flags(), bus.cpu_rdata, exp_d);
      end
      tick();
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h77;
      smp();
      n_chk++;
      if ({flags(), bus.mem_addr, bus.mem_wdata} !== {6'b111010, 32'h80, 32'hA5A5_A5A5}) begin
         n_fail++; $display("FAIL conflict2_ext_first: flags=%b addr=%h wdata=%h required 111010 00000080 a5a5a5a5",
                            flags(), bus.mem_addr, bus.mem_wdata);
      end
      tick();
      bus.ext_we = 1'b0;
      ext_q.push_back(32'hA5A5_A5A5);
      smp();
      n_chk++;
      if ({flags(), bus.mem_addr, bus.mem_wdata} !== {6'b110000, 32'h20, 32'h77}) begin
         n_fail++; $display("FAIL conflict3_cpu_first: flags=%b addr=%h wdata=%h required 110000 00000020 00000077",
                            flags(), bus.mem_addr, bus.mem_wdata);
      end
      tick();
      bus.cpu_req = 1'b0;
      smp();
      n_chk++;
      if ({flags(), bus.mem_addr} !== {6'b100010, 32'h80}) begin
         n_fail++; $display("FAIL ext_read_gnt: flags=%b addr=%h required 100010 00000080", flags(), bus.mem_addr);
      end
      tick();
      bus.ext_req = 1'b0;
      tick(); smp();
      exp_d = ext_q.pop_front();
      n_chk++;
      if ({flags(), bus.ext_rdata} !== {6'b000001, exp_d}) begin
         n_fail++; $display("FAIL ext_read_return: flags=%b rdata=%h required 000001 %h", flags(), bus.ext_rdata, exp_d);
      end
`ifdef DMEM_ARB_PERF_EN
      n_chk++;
      if (perf_ext_cnt !== 32'd2) begin
         n_fail++; $display("FAIL perf_ext: got %0d required 2", perf_ext_cnt);
      end
`endif
      tick();
   endtask

   task automatic test_ext_inflight();
      bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h40;
      ext_q.push_back(32'hDEAD_BEEF);
      smp();
      n_chk++;
      if (flags() !== 6'b100010) begin
         n_fail++; $display("FAIL inflight_ext_issue: flags=%b required 100010", flags());
      end
      tick();
      bus.ext_req = 1'b0;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h14;
      cpu_q.push_back(32'd6);
      smp();
      n_chk++;
      if (flags() !== 6'b001000) begin
         n_fail++; $display("FAIL inflight_cpu_blocked: flags=%b required 001000", flags());
      end
      tick(); smp();
      exp_d = ext_q.pop_front();
      n_chk++;
      if ({flags(), bus.ext_rdata} !== {6'b001001, exp_d}) begin
         n_fail++; $display("FAIL inflight_ext_return: flags=%b rdata=%h required 001001 %h", flags(), bus.ext_rdata, exp_d);
      end
      tick(); smp();
      n_chk++;
      if ({flags(), bus.mem_addr} !== {6'b101000, 32'h14}) begin
         n_fail++; $display("FAIL inflight_cpu_issue: flags=%b addr=%h required 101000 00000014", flags(), bus.mem_addr);
      end
      n = 0;
      while (!bus.cpu_rvalid && n < 8) begin
         tick(); smp(); n++;
      end
      exp_d = cpu_q.pop_front();
      n_chk++;
      if (n !== LAT || bus.cpu_rdata !== exp_d || bus.cpu_stall !== 1'b0 || bus.ext_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL inflight_cpu_return: cycles=%0d rdata=%h stall=%b ext_rdata=%h required %0d %h 0 deadbeef",
                            n, bus.cpu_rdata, bus.cpu_stall, bus.ext_rdata, LAT, exp_d);
      end
      tick();
      bus.cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_read();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
      smp();
      n_chk++;
      if (flags() !== 6'b101000) begin
         n_fail++; $display("FAIL midrst_issue: flags=%b required 101000", flags());
      end
      tick();
      rst = 1'b0;
      bus.cpu_req = 1'b0;
      smp();
      n_chk++;
      if ({flags(), bus.cpu_rdata, bus.ext_rdata, bus.mem_addr} !== '0) begin
         n_fail++; $display("FAIL midrst_outputs: flags=%b cpu_rdata=%h ext_rdata=%h required all 0",
                            flags(), bus.cpu_rdata, bus.ext_rdata);
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         smp();
         n_chk++;
         if (flags() !== 6'b000000) begin
            n_fail++; $display("FAIL midrst_quiet_%0d: flags=%b required 000000", i, flags());
         end
         tick();
      end
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h24; bus.cpu_wdata = 32'h99;
      bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h84; bus.ext_wdata = 32'h55;
      smp();
      n_chk++;
      if ({flags(), bus.mem_addr} !== {6'b110000, 32'h24}) begin
         n_fail++; $display("FAIL midrst_cpu_wins: flags=%b addr=%h required 110000 00000024", flags(), bus.mem_addr);
      end
      tick();
      bus.cpu_req = 1'b0;
      smp();
      n_chk++;
      if ({flags(), bus.mem_addr} !== {6'b110010, 32'h84}) begin
         n_fail++; $display("FAIL midrst_ext_next: flags=%b addr=%h required 110010 00000084", flags(), bus.mem_addr);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fl = '0;
      test_reset();
      test_cpu_load();
      test_back_to_back();
      test_conflict();
      test_ext_inflight();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
